// File: rtl/roll_pkg.sv
// Shared constants, FSM states and the prescaler-to-window decode for roll mode.
// The scaler imports the same decode so its bit-window thresholds always match N.
package roll_pkg;

    localparam int unsigned SAMPLE_W  = 12;
    localparam int unsigned ACC_W     = 42;
    localparam int unsigned PRE_SHIFT = 12;
    localparam int unsigned PRESC_W   = 16;
    localparam int unsigned MAX_WIN   = 65536;
    localparam int unsigned WIN_W     = PRESC_W + 1;
    localparam int unsigned LOG_W     = 5;

    typedef enum logic [0:0] {
        StIdle,
        StAccum
    } state_e;

    // log2 of the smallest power of two >= prescaler, never below 1 (N >= 2).
    // Scanning downward lets the smallest matching exponent win.
    function automatic logic [LOG_W-1:0] win_log2(input logic [PRESC_W-1:0] presc);
        logic [LOG_W-1:0] lg;
        lg = LOG_W'(PRESC_W);
        for (int k = PRESC_W; k >= 1; k--) begin
            if (WIN_W'(presc) <= (WIN_W'(1) << k)) begin
                lg = LOG_W'(k);
            end
        end
        return lg;
    endfunction

endpackage

// File: rtl/roll_accumulator_if.sv
// Sample-stream input and window-sum output bundle of the roll-mode accumulator.
interface roll_accumulator_if;
    import roll_pkg::*;

    logic                enable;
    logic [PRESC_W-1:0]  prescaler;
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic [ACC_W-1:0]    value;
    logic                value_valid;
    logic [WIN_W-1:0]    window_len;

    modport master (
        output enable, prescaler, sample_in, sample_valid,
        input  value, value_valid, window_len
    );

    modport slave (
        input  enable, prescaler, sample_in, sample_valid,
        output value, value_valid, window_len
    );

endinterface

// File: rtl/roll_window_decode.sv
// Combinational prescaler -> {N, log2 N} decoder for the roll-mode window.
module roll_window_decode
    import roll_pkg::*;
(
    input  logic [PRESC_W-1:0] prescaler_i,
    output logic [WIN_W-1:0]   win_len_o,
    output logic [LOG_W-1:0]   win_log2_o
);

    always_comb begin
        win_log2_o = win_log2(prescaler_i);
        win_len_o  = WIN_W'(1) << win_log2_o;
    end

endmodule

// File: rtl/roll_accumulator.sv
// Roll-mode decimating accumulator: sums N pre-shifted samples and strobes the
// completed window sum out for the scaler to narrow to a display sample.
module roll_accumulator
    import roll_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    roll_accumulator_if.slave  bus
);

    state_e               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [PRESC_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]     value_q, value_d;
    logic                 value_valid_q, value_valid_d;
    logic [WIN_W-1:0]     window_len_q, window_len_d;
    logic [LOG_W-1:0]     win_log2_q, win_log2_d;

    logic [WIN_W-1:0]     dec_len;
    logic [LOG_W-1:0]     dec_log2;
    logic [ACC_W-1:0]     sample_ext;
    logic [ACC_W-1:0]     acc_sum;
    logic [PRESC_W-1:0]   last_idx;
    logic                 cnt_last;

    roll_window_decode u_decode (
        .prescaler_i (bus.prescaler),
        .win_len_o   (dec_len),
        .win_log2_o  (dec_log2)
    );

    always_comb begin
        sample_ext = ACC_W'(bus.sample_in) << PRE_SHIFT;
        acc_sum    = acc_q + sample_ext;
        // For N = 65536 the 16-bit shift wraps to 0, so last_idx becomes 16'hFFFF.
        last_idx   = (PRESC_W'(1) << win_log2_q) - PRESC_W'(1);
        cnt_last   = (cnt_q == last_idx);
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        window_len_d  = window_len_q;
        win_log2_d    = win_log2_q;

        unique case (state_q)
            StIdle: begin
                acc_d = '0;
                cnt_d = '0;
                if (bus.enable) begin
                    window_len_d = dec_len;
                    win_log2_d   = dec_log2;
                    state_d      = StAccum;
                end
            end
            StAccum: begin
                if (!bus.enable) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (bus.sample_valid) begin
                    if (cnt_last) begin
                        value_d       = acc_sum;
                        value_valid_d = 1'b1;
                        acc_d         = '0;
                        cnt_d         = '0;
                        window_len_d  = dec_len;
                        win_log2_d    = dec_log2;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + PRESC_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            acc_q         <= '0;
            cnt_q         <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            window_len_q  <= WIN_W'(2);
            win_log2_q    <= LOG_W'(1);
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            window_len_q  <= window_len_d;
            win_log2_q    <= win_log2_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.value_valid = value_valid_q;
    assign bus.window_len  = window_len_q;

endmodule
